store_merge: RTL and testbench

Multicycle store unit that narrows a register operand into a 32-bit word-only data memory. It is the write-side counterpart of the offset/load extension logic: extension widens 16/8-bit quantities to 32 bits, and store_merge packs byte/half/word data back into the addressed lane. Without byte enables this takes a read-modify-write sequence. It sits between the datapath's MEM-stage control and the data memory port.

---
 rtl/store_merge_pkg.sv | 33 +++
 rtl/store_lane_merge.sv | 29 ++
 rtl/store_merge.sv | 162 ++++++++++++++++
 tb/tb_store_merge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_merge_pkg.sv
// Shared constants for the store_merge slice: width codes, FSM states and lane helpers.
package store_merge_pkg;

  localparam logic [1:0] Smb = 2'b00;
  localparam logic [1:0] Smh = 2'b01;
  localparam logic [1:0] Smw = 2'b10;

  typedef enum logic [1:0] {
    Sm_IDLE = 2'd0,
    Sm_RD   = 2'd1,
    Sm_WR   = 2'd2,
    Sm_DONE = 2'd3
  } sm_state_e;

  // Reserved width (2'b11) is reported through the same error path as misalignment.
  function automatic logic store_misaligned(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      Smb:     return 1'b0;
      Smh:     return lo[0];
      Smw:     return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] store_replicate(input logic [1:0] width, input logic [31:0] data);
    case (width)
      Smb:     return {4{data[7:0]}};
      Smh:     return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane packer: places byte/half/word store data into its little-endian lanes.
module store_lane_merge
  import store_merge_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  width_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o,
  output logic [3:0]  be_o
);

  logic [31:0] lane_data;

  always_comb begin
    lane_data = store_replicate(width_i, wdata_i);
    case (width_i)
      Smb:     be_o = 4'b0001 << addr_lo_i;
      Smh:     be_o = 4'b0011 << {addr_lo_i[1], 1'b0};
      Smw:     be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (be_o[i]) merged_o[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_merge.sv
// Multicycle narrow-store unit for a word-only memory (read-modify-write by default).
// Define STORE_MERGE_BE_EN for a byte-enable memory: single write, no read.
module store_merge
  import store_merge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic [1:0]        Sm_width_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              mem_wr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_wack_i
`ifdef STORE_MERGE_BE_EN
  ,
  output logic [3:0]        mem_be_o
`endif
);

`ifdef STORE_MERGE_BE_EN
  localparam bit BeEn = 1'b1;
`else
  localparam bit BeEn = 1'b0;
`endif

  sm_state_e         state_q;
  logic              busy_q, done_q, err_q, rd_q, wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [1:0]        width_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wdata_q;

  logic [31:0] lm_old, lm_wdata, lm_merged;
  logic [1:0]  lm_width, lm_lo;
  logic [3:0]  lm_be;
  logic        go_direct;

  // In IDLE the merger sees the live request (word or byte-enable path);
  // in RD it merges the latched operand into the returning read data.
  always_comb begin
    lm_old   = store_replicate(Sm_width_i, wdata_i);
    lm_wdata = wdata_i;
    lm_width = Sm_width_i;
    lm_lo    = addr_i[1:0];
    if (state_q == Sm_RD) begin
      lm_old   = mem_rdata_i;
      lm_wdata = wdata_q;
      lm_width = width_q;
      lm_lo    = addr_lo_q;
    end
  end

  assign go_direct = BeEn || (Sm_width_i == Smw);

  store_lane_merge u_lane_merge (
    .old_i    (lm_old),
    .wdata_i  (lm_wdata),
    .width_i  (lm_width),
    .addr_lo_i(lm_lo),
    .merged_o (lm_merged),
    .be_o     (lm_be)
  );

`ifdef STORE_MERGE_BE_EN
  logic [3:0] be_q;
  assign mem_be_o = be_q;
`else
  logic be_unused;
  assign be_unused = ^lm_be;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= Sm_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      width_q     <= '0;
      addr_lo_q   <= '0;
      wdata_q     <= '0;
`ifdef STORE_MERGE_BE_EN
      be_q        <= '0;
`endif
    end else begin
      case (state_q)
        Sm_IDLE: begin
          if (req_i) begin
            width_q    <= Sm_width_i;
            addr_lo_q  <= addr_i[1:0];
            wdata_q    <= wdata_i;
            mem_addr_q <= {addr_i[ADDR_W-1:2], 2'b00};
            busy_q     <= 1'b1;
            if (store_misaligned(Sm_width_i, addr_i[1:0])) begin
              state_q <= Sm_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (go_direct) begin
              state_q     <= Sm_WR;
              wr_q        <= 1'b1;
              mem_wdata_q <= lm_merged;
`ifdef STORE_MERGE_BE_EN
              be_q        <= lm_be;
`endif
            end else begin
              state_q <= Sm_RD;
              rd_q    <= 1'b1;
            end
          end
        end
        Sm_RD: begin
          if (mem_rvalid_i) begin
            state_q     <= Sm_WR;
            rd_q        <= 1'b0;
            wr_q        <= 1'b1;
            mem_wdata_q <= lm_merged;
          end
        end
        Sm_WR: begin
          if (mem_wack_i) begin
            state_q <= Sm_DONE;
            wr_q    <= 1'b0;
            done_q  <= 1'b1;
`ifdef STORE_MERGE_BE_EN
            be_q    <= '0;
`endif
          end
        end
        Sm_DONE: begin
          state_q <= Sm_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= Sm_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign mem_rd_o    = rd_q;
  assign mem_wr_o    = wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_store_merge.sv
// Bench for store_merge: directed cases plus random stores against a byte-level memory model.
module tb_store_merge;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_i = 1'b0;
  logic [1:0]  Sm_width_i = 2'b00;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_wr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_wack_i = 1'b0;
`ifdef STORE_MERGE_BE_EN
  logic [3:0]  mem_be_o;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [logic [31:0]];

  store_merge #(.ADDR_W(32)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_i       (req_i),
    .Sm_width_i  (Sm_width_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rd_o    (mem_rd_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_wr_o    (mem_wr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wack_i  (mem_wack_i)
`ifdef STORE_MERGE_BE_EN
    ,
    .mem_be_o    (mem_be_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Reference: memory as four bytes, store bytes of d at lanes lo..lo+n-1.
  function automatic logic [31:0] model_word(input logic [31:0] old, input int n, input int lo,
                                             input logic [31:0] d);
    logic [7:0] b[4];
    for (int j = 0; j < 4; j++) b[j] = old[8*j +: 8];
    for (int i = 0; i < n; i++) b[lo+i] = d[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [31:0] model_repl(input int n, input logic [31:0] d);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = d[8*(j % n) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] model_be(input int n, input int lo);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < n; i++) be[lo+i] = 1'b1;
    return be;
  endfunction

  task automatic do_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                          input int rdly, input int wdly, output logic [31:0] wr_data);
    logic [31:0] word_a, old, wd_first, expv;
    logic [3:0]  exp_be;
    int n, lo, cyc, done_cyc, rd_cnt, wr_cnt, bad_cnt, exp_done;
    logic err_exp, needs_rd, err_seen, be_en;
`ifdef STORE_MERGE_BE_EN
    be_en = 1'b1;
`else
    be_en = 1'b0;
`endif
    word_a = {a[31:2], 2'b00};
    lo = int'(a[1:0]);
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    err_exp = (w == 2'b11) || (lo % n != 0);
    needs_rd = !err_exp && !be_en && n != 4;
    old = mem_read(word_a);
    exp_be = err_exp ? 4'b0 : model_be(n, lo);
    if (!err_exp) exp_q.push_back(be_en ? model_repl(n, d) : model_word(old, n, lo, d));
    wr_data = '0; wd_first = '0; err_seen = 1'b0;
    rd_cnt = 0; wr_cnt = 0; bad_cnt = 0; done_cyc = 0;

    @(negedge clk_i);
    req_i = 1'b1; Sm_width_i = w; addr_i = a; wdata_i = d;
    @(posedge clk_i); #1;
    cyc = 1;
    while (cyc <= 60 && done_cyc == 0) begin
      mem_rvalid_i = 1'b0; mem_wack_i = 1'b0; mem_rdata_i = $urandom;
      if (busy_o !== 1'b1) bad_cnt++;
      if (mem_rd_o === 1'b1) begin
        rd_cnt++;
        if (mem_addr_o !== word_a || mem_wr_o === 1'b1) bad_cnt++;
        if (rd_cnt == rdly + 1) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = mem_read(word_a);
        end
      end
      if (mem_wr_o === 1'b1) begin
        wr_cnt++;
        if (wr_cnt == 1) wd_first = mem_wdata_o;
        else if (mem_wdata_o !== wd_first) bad_cnt++;
        if (mem_addr_o !== word_a) bad_cnt++;
`ifdef STORE_MERGE_BE_EN
        if (mem_be_o !== exp_be) bad_cnt++;
`endif
        if (wr_cnt == wdly + 1) begin
          mem_wack_i = 1'b1;
          wr_data = mem_wdata_o;
        end
      end
`ifdef STORE_MERGE_BE_EN
      if (mem_wr_o !== 1'b1 && mem_be_o !== 4'b0000) bad_cnt++;
`endif
      if (done_o === 1'b1) begin
        done_cyc = cyc;
        err_seen = err_o;
        req_i = 1'b0;
      end else begin
        // Requests while busy must be ignored.
        req_i = 1'($urandom_range(0, 1));
        Sm_width_i = 2'($urandom_range(0, 3));
        addr_i = $urandom;
        wdata_i = $urandom;
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    req_i = 1'b0; mem_rvalid_i = 1'b0; mem_wack_i = 1'b0;
    check("timeout", {31'b0, done_cyc != 0}, 32'd1);
    if (done_cyc != 0) begin
      exp_done = err_exp ? 1 : needs_rd ? 3 + rdly + wdly : 2 + wdly;
      check("done_cycle", done_cyc, exp_done);
      check("err", {31'b0, err_seen}, {31'b0, err_exp});
      check("rd_cycles", rd_cnt, needs_rd ? rdly + 1 : 0);
      check("wr_cycles", wr_cnt, err_exp ? 0 : wdly + 1);
      check("protocol", bad_cnt, 0);
      if (!err_exp) begin
        expv = exp_q.pop_front();
        check("wdata", wr_data, expv);
        mem[word_a] = model_word(old, n, lo, d);
      end
    end else begin
      exp_q.delete();
    end
    @(posedge clk_i); #1;
    check("idle_after", {27'b0, busy_o, done_o, err_o, mem_rd_o, mem_wr_o}, 32'd0);
  endtask

  logic [31:0] wd;

  initial begin
    #2;
    check("reset_ctl", {27'b0, busy_o, done_o, err_o, mem_rd_o, mem_wr_o}, 32'd0);
    check("reset_addr", mem_addr_o, 32'd0);
    check("reset_wdata", mem_wdata_o, 32'd0);
`ifdef STORE_MERGE_BE_EN
    check("reset_be", {28'b0, mem_be_o}, 32'd0);
`endif
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); rst_n_i = 1'b1;

    mem[32'h100] = 32'h11223344;
    do_store(2'b00, 32'h102, 32'h000000AB, 0, 0, wd);
`ifndef STORE_MERGE_BE_EN
    check("sb_0x102", wd, 32'h11AB3344);
`endif
    do_store(2'b01, 32'h102, 32'h0000BEEF, 3, 0, wd);
`ifndef STORE_MERGE_BE_EN
    check("sh_0x102", wd, 32'hBEEF3344);
`endif
    do_store(2'b10, 32'h104, 32'hDEADBEEF, 0, 0, wd);
    check("sw_0x104", wd, 32'hDEADBEEF);
    do_store(2'b01, 32'h101, 32'h1234, 0, 0, wd);
    do_store(2'b10, 32'h106, 32'h5678, 0, 0, wd);
    do_store(2'b11, 32'h100, 32'h9ABC, 0, 0, wd);
    do_store(2'b00, 32'h103, 32'h000000AB, 1, 2, wd);
`ifdef STORE_MERGE_BE_EN
    check("sb_be_0x103", wd, 32'hABABABAB);
`endif

    // Reset in the middle of a write that is never acknowledged.
    @(negedge clk_i);
    req_i = 1'b1; Sm_width_i = 2'b10; addr_i = 32'h108; wdata_i = 32'hCAFEF00D;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1;
    check("rst_mid_ctl", {27'b0, busy_o, done_o, err_o, mem_rd_o, mem_wr_o}, 32'd0);
    check("rst_mid_addr", mem_addr_o, 32'd0);
    check("rst_mid_wdata", mem_wdata_o, 32'd0);
`ifdef STORE_MERGE_BE_EN
    check("rst_mid_be", {28'b0, mem_be_o}, 32'd0);
`endif
    @(negedge clk_i); rst_n_i = 1'b1;
    do_store(2'b00, 32'h109, 32'h0000005A, 0, 0, wd);

    for (int k = 0; k < 150; k++) begin
      do_store(2'($urandom_range(0, 3)), 32'h200 + 32'($urandom_range(0, 63)), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
